// File: rtl/mem_cache_pkg.sv
// Shared types and sizing helpers for the MEM-stage data cache.
// Latency: n/a (package only).
// Backpressure: n/a.
package mem_cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // The tag keeps every word-address bit above the index, so an address below BASE_ADDR never aliases.
    function automatic int unsigned tag_width(input int unsigned lines);
        return 32 - $clog2(lines);
    endfunction

endpackage

// File: rtl/mem_cache_if.sv
// Request/completion bus between the memory stage and the slow data SRAM.
// Latency: set by the SRAM, from the first sram_req cycle to the sram_ready pulse.
// Backpressure: the master holds req/we/addr/wdata until sram_ready pulses.
interface mem_cache_if;
    logic        sram_req;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output sram_req, sram_we, sram_addr, sram_wdata,
        input  sram_rdata, sram_ready
    );

    modport slave (
        input  sram_req, sram_we, sram_addr, sram_wdata,
        output sram_rdata, sram_ready
    );
endinterface

// File: rtl/cache_line_array.sv
// Direct-mapped valid/tag/data storage, one word per line.
// Latency: combinational read, write takes effect at the next clock edge.
// Backpressure: none; the owner decides when to write.
module cache_line_array #(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TAG_W     = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: a cleared valid bit masks whatever they hold.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/mem_cache_stage.sv
// MIPS memory stage with write-through, no-write-allocate cache (MEM_CACHE_EN) and MEM/WB register.
// Latency: load hit 0 stall cycles; miss/store stall until sram_ready, MEM/WB updates one edge later.
// Backpressure: ready_MEM low freezes upstream; MEM/WB takes bubbles meanwhile.
module mem_cache_stage
    import mem_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 64,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               WB_EN_MEM,
    input  logic               MEM_R_EN_MEM,
    input  logic               MEM_W_EN_MEM,
    input  logic [4:0]         DST_MEM,
    input  logic [31:0]        ALU_result_MEM,
    input  logic [31:0]        ST_val_MEM,
    mem_cache_if.master        sram,
    output logic               ready_MEM,
    output logic               WB_EN_WB,
    output logic               MEM_R_EN_WB,
    output logic [4:0]         DST_WB,
    output logic [31:0]        Mem_data_WB,
    output logic [31:0]        ALU_result_WB
);

    if ((NUM_LINES < 2) || ((NUM_LINES & (NUM_LINES - 1)) != 0)) begin : g_bad_lines
        $error("NUM_LINES must be a power of two of at least 2");
    end

    state_t      state_q;
    state_t      state_d;
    logic [31:0] word_addr;
    logic        is_store;
    logic        is_load;
    logic        hit;
    logic [31:0] line_data;
    logic [31:0] load_data;
    logic        req_c;
    logic        we_c;

    assign word_addr = (ALU_result_MEM - BASE_ADDR) >> 2;
    assign is_store  = MEM_W_EN_MEM;
    assign is_load   = MEM_R_EN_MEM & ~MEM_W_EN_MEM;

`ifdef MEM_CACHE_EN
    localparam int unsigned IDX_W = idx_width(NUM_LINES);
    localparam int unsigned TAG_W = tag_width(NUM_LINES);

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             fill;
    logic             update;

    assign idx    = word_addr[IDX_W-1:0];
    assign tag    = word_addr[31:IDX_W];
    assign fill   = (state_q == RD_WAIT) && sram.sram_ready;
    // Write hits refresh the line on entry to WR_WAIT; write misses leave the array alone.
    assign update = (state_q == IDLE) && is_store && hit;

    cache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx),
        .rd_tag  (tag),
        .hit     (hit),
        .rd_data (line_data),
        .wr_en   (fill | update),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data (fill ? sram.sram_rdata : ST_val_MEM)
    );
`else
    assign hit       = 1'b0;
    assign line_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_MEM = 1'b1;
        load_data = line_data;
        unique case (state_q)
            IDLE: begin
                if (is_store) begin
                    state_d   = WR_WAIT;
                    ready_MEM = 1'b0;
                end else if (is_load && !hit) begin
                    state_d   = RD_WAIT;
                    ready_MEM = 1'b0;
                end
            end
            RD_WAIT: begin
                ready_MEM = sram.sram_ready;
                load_data = sram.sram_rdata;
                if (sram.sram_ready) state_d = IDLE;
            end
            WR_WAIT: begin
                ready_MEM = sram.sram_ready;
                if (sram.sram_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The request starts in the IDLE cycle that detects it; EX/MEM is frozen, so address and data stay stable.
    assign req_c = rst && ((state_q != IDLE) || is_store || (is_load && !hit));
    assign we_c  = rst && ((state_q == WR_WAIT) || ((state_q == IDLE) && is_store));

    assign sram.sram_req   = req_c;
    assign sram.sram_we    = we_c;
    assign sram.sram_addr  = req_c ? word_addr : '0;
    assign sram.sram_wdata = we_c ? ST_val_MEM : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            WB_EN_WB      <= 1'b0;
            MEM_R_EN_WB   <= 1'b0;
            DST_WB        <= '0;
            Mem_data_WB   <= '0;
            ALU_result_WB <= '0;
        end else if (ready_MEM) begin
            WB_EN_WB      <= WB_EN_MEM;
            MEM_R_EN_WB   <= MEM_R_EN_MEM;
            DST_WB        <= DST_MEM;
            Mem_data_WB   <= load_data;
            ALU_result_WB <= ALU_result_MEM;
        end else begin
            WB_EN_WB    <= 1'b0;
            MEM_R_EN_WB <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_cache_stage.sv
// Directed bench for mem_cache_stage with a latency-programmable SRAM model.
`timescale 1ns/1ps
module tb_mem_cache_stage;
    import mem_cache_pkg::*;

`ifdef MEM_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  dst = '0;
    logic [31:0] alu = '0;
    logic [31:0] st_val = '0;

    logic        ready_mem;
    logic        wb_en_wb;
    logic        mem_r_en_wb;
    logic [4:0]  dst_wb;
    logic [31:0] mem_data_wb;
    logic [31:0] alu_wb;

    int checks = 0;
    int errors = 0;
    int lat = 4;

    mem_cache_if sram_bus ();

    mem_cache_stage #(.NUM_LINES(64), .BASE_ADDR(32'd1024)) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_EN_MEM      (wb_en),
        .MEM_R_EN_MEM   (rd_en),
        .MEM_W_EN_MEM   (wr_en),
        .DST_MEM        (dst),
        .ALU_result_MEM (alu),
        .ST_val_MEM     (st_val),
        .sram           (sram_bus),
        .ready_MEM      (ready_mem),
        .WB_EN_WB       (wb_en_wb),
        .MEM_R_EN_WB    (mem_r_en_wb),
        .DST_WB         (dst_wb),
        .Mem_data_WB    (mem_data_wb),
        .ALU_result_WB  (alu_wb)
    );

    always #5 clk = ~clk;

    // SRAM model: sram_ready pulses in the lat-th cycle of a request (lat >= 2).
    logic [31:0] mem [128];
    logic        rdy_q = 1'b0;
    logic [31:0] rdata_q = '0;
    int          cnt = 0;
    bit          loaded = 1'b0;

    assign sram_bus.sram_ready = rdy_q;
    assign sram_bus.sram_rdata = rdata_q;

    always @(posedge clk) begin
        if (!loaded) begin
            mem[1] <= 32'hDEADBEEF;
            loaded <= 1'b1;
        end
        if (!rst) begin
            cnt   <= 0;
            rdy_q <= 1'b0;
        end else if (rdy_q) begin
            rdy_q <= 1'b0;
            cnt   <= 0;
            if (sram_bus.sram_we) mem[sram_bus.sram_addr[6:0]] <= sram_bus.sram_wdata;
        end else if (sram_bus.sram_req) begin
            if (cnt + 1 >= lat - 1) begin
                rdy_q   <= 1'b1;
                rdata_q <= mem[sram_bus.sram_addr[6:0]];
            end
            cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one EX/MEM op, hold it while ready_MEM is low, return after the capturing edge.
    task automatic op(input string tag, input logic w, input logic r, input logic wb,
                      input logic [4:0] d, input logic [31:0] a, input logic [31:0] wd,
                      output int stalls, output int reqs, output int bad_bubbles,
                      output logic [31:0] addr_seen, output logic we_seen);
        bit done;
        stalls = 0; reqs = 0; bad_bubbles = 0; addr_seen = 32'hFFFF_FFFF; we_seen = 1'b0; done = 1'b0;
        @(negedge clk);
        wr_en = w; rd_en = r; wb_en = wb; dst = d; alu = a; st_val = wd;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (sram_bus.sram_req) begin
                reqs++;
                addr_seen = sram_bus.sram_addr;
                we_seen   = we_seen | sram_bus.sram_we;
            end
            if (i > 0 && wb_en_wb !== 1'b0) bad_bubbles++;
            if (ready_mem === 1'b1) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (!done) chk({tag, "_timeout"}, {31'd0, ready_mem}, 32'd1);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; wb_en = 1'b0; dst = '0; alu = '0; st_val = '0;
    endtask

    int          stalls, reqs, bad;
    logic [31:0] addr_seen;
    logic        we_seen;

    initial begin
        // Reset held two edges
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_en", {31'd0, wb_en_wb}, 32'd0);
        chk("rst_mem_r_en", {31'd0, mem_r_en_wb}, 32'd0);
        chk("rst_dst", {27'd0, dst_wb}, 32'd0);
        chk("rst_mem_data", mem_data_wb, 32'd0);
        chk("rst_alu", alu_wb, 32'd0);
        chk("rst_req", {31'd0, sram_bus.sram_req}, 32'd0);
        chk("rst_we", {31'd0, sram_bus.sram_we}, 32'd0);
        chk("rst_addr", sram_bus.sram_addr, 32'd0);
        chk("rst_wdata", sram_bus.sram_wdata, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, ready_mem}, 32'd1);

        // Cold load from 1028, L=4
        lat = 4;
        op("cold", 1'b0, 1'b1, 1'b1, 5'd7, 32'd1028, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("cold_stalls", stalls, 32'd3);
        chk("cold_reqs", reqs, 32'd4);
        chk("cold_addr", addr_seen, 32'd1);
        chk("cold_bubbles", bad, 32'd0);
        chk("cold_data", mem_data_wb, 32'hDEADBEEF);
        chk("cold_wb_en", {31'd0, wb_en_wb}, 32'd1);
        chk("cold_mem_r_en", {31'd0, mem_r_en_wb}, 32'd1);
        chk("cold_dst", {27'd0, dst_wb}, 32'd7);

        // Repeat load: hit with the cache, full SRAM read without it
        op("rehit", 1'b0, 1'b1, 1'b1, 5'd8, 32'd1028, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("rehit_stalls", stalls, CACHE ? 32'd0 : 32'd3);
        chk("rehit_reqs", reqs, CACHE ? 32'd0 : 32'd4);
        chk("rehit_data", mem_data_wb, 32'hDEADBEEF);
        chk("rehit_dst", {27'd0, dst_wb}, 32'd8);

        // Store hit then load, L=2
        lat = 2;
        op("st_hit", 1'b1, 1'b0, 1'b0, 5'd0, 32'd1028, 32'h12345678, stalls, reqs, bad, addr_seen, we_seen);
        chk("st_hit_stalls", stalls, 32'd1);
        chk("st_hit_reqs", reqs, 32'd2);
        chk("st_hit_we", {31'd0, we_seen}, 32'd1);
        chk("st_hit_addr", addr_seen, 32'd1);
        chk("st_hit_wb_en", {31'd0, wb_en_wb}, 32'd0);
        chk("st_hit_alu", alu_wb, 32'd1028);
        chk("st_hit_sram", mem[1], 32'h12345678);
        op("ld_after_st", 1'b0, 1'b1, 1'b1, 5'd9, 32'd1028, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("ld_after_st_stalls", stalls, CACHE ? 32'd0 : 32'd1);
        chk("ld_after_st_data", mem_data_wb, 32'h12345678);

        // Store miss to the same index must not allocate
        op("st_miss", 1'b1, 1'b0, 1'b0, 5'd0, 32'd1284, 32'hCAFEF00D, stalls, reqs, bad, addr_seen, we_seen);
        chk("st_miss_stalls", stalls, 32'd1);
        chk("st_miss_addr", addr_seen, 32'd65);
        op("ld_keep", 1'b0, 1'b1, 1'b1, 5'd10, 32'd1028, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("ld_keep_stalls", stalls, CACHE ? 32'd0 : 32'd1);
        chk("ld_keep_data", mem_data_wb, 32'h12345678);
        op("ld_alias", 1'b0, 1'b1, 1'b1, 5'd3, 32'd1284, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("ld_alias_stalls", stalls, 32'd1);
        chk("ld_alias_data", mem_data_wb, 32'hCAFEF00D);

        // Read and write both set: handled as a store
        op("both", 1'b1, 1'b1, 1'b0, 5'd0, 32'd1028, 32'h0BADCAFE, stalls, reqs, bad, addr_seen, we_seen);
        chk("both_we", {31'd0, we_seen}, 32'd1);
        chk("both_sram", mem[1], 32'h0BADCAFE);
        op("ld_both", 1'b0, 1'b1, 1'b1, 5'd11, 32'd1028, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("ld_both_data", mem_data_wb, 32'h0BADCAFE);

        // Reset in the middle of a read miss
        lat = 4;
        @(negedge clk);
        rd_en = 1'b1; wb_en = 1'b1; dst = 5'd4; alu = 32'd1032;
        #1;
        chk("abort_req_start", {31'd0, sram_bus.sram_req}, 32'd1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_req_drop", {31'd0, sram_bus.sram_req}, 32'd0);
        chk("abort_wb_en", {31'd0, wb_en_wb}, 32'd0);
        @(negedge clk);
        rst = 1'b1; rd_en = 1'b0; wb_en = 1'b0; dst = '0; alu = '0;
        #1;
        chk("abort_idle_ready", {31'd0, ready_mem}, 32'd1);
        chk("abort_idle_req", {31'd0, sram_bus.sram_req}, 32'd0);
        op("post_abort", 1'b0, 1'b1, 1'b1, 5'd12, 32'd1028, 32'd0, stalls, reqs, bad, addr_seen, we_seen);
        chk("post_abort_stalls", stalls, 32'd3);
        chk("post_abort_data", mem_data_wb, 32'h0BADCAFE);
        chk("post_abort_dst", {27'd0, dst_wb}, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
